// File: rtl/fir_pkg.sv
// Shared types and default dimensions for the FIR sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  // Default datapath dimensions used across the FIR blocks.
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_TAPS   = 8;

  // Sequencer states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // One coefficient bank at the default dimensions.
  typedef logic [DEF_DATA_WIDTH-1:0] coef_bank_t [DEF_NUM_TAPS];

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow bank written by the config port, active bank feeds the MAC.
// Latency: a shadow write or a commit takes effect at the next clock edge.
// Backpressure: none; config strobes are always accepted, out-of-range addresses are dropped.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int ADDR_W     = $clog2(NUM_TAPS)
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           cfg_we,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [DATA_WIDTH-1:0]          cfg_wdata,
  input  logic                           cfg_commit,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] coefs
);

  logic [DATA_WIDTH-1:0] shadowBank [NUM_TAPS];
  logic [DATA_WIDTH-1:0] activeBank [NUM_TAPS];
  logic                  addrOk;

  // Addresses past the last tap are silently ignored rather than aliased.
  assign addrOk = ({1'b0, cfg_addr} < (ADDR_W+1)'(NUM_TAPS));

  // Shadow bank: one coefficient per write strobe, writable in any sequencer state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_TAPS; i++) shadowBank[i] <= '0;
    end else if (cfg_we && addrOk) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (cfg_addr == ADDR_W'(i)) shadowBank[i] <= cfg_wdata;
      end
    end
  end

  // Active bank: whole-bank copy on commit; reads the pre-edge shadow, so a
  // write landing on the same edge is left for the next commit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_TAPS; i++) activeBank[i] <= '0;
    end else if (cfg_commit) begin
      for (int i = 0; i < NUM_TAPS; i++) activeBank[i] <= shadowBank[i];
    end
  end

  // Flatten the active bank, tap 0 in the least significant lane.
  always_comb begin
    coefs = '0;
    for (int i = 0; i < NUM_TAPS; i++) coefs[i*DATA_WIDTH +: DATA_WIDTH] = activeBank[i];
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: gates sample intake, tracks tap-window fill, registers MAC results into a one-entry output stage.
// Latency: a result-producing sample accepted at edge k is presented on m_valid after edge k+1.
// Backpressure: s_ready drops only while a capture is pending behind a stalled output (m_valid && !m_ready).
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int ADDR_W     = $clog2(NUM_TAPS)
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           cfg_we,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [DATA_WIDTH-1:0]          cfg_wdata,
  input  logic                           cfg_commit,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           shift_en,
  output logic                           shift_clr,
  output logic [DATA_WIDTH-1:0]          shift_data,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] coefs,
  input  logic [DATA_WIDTH-1:0]          mac_result,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           busy,
  output logic [1:0]                     state_o
);

  // Fill counter must be able to hold NUM_TAPS itself.
  localparam int               CNT_W     = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(NUM_TAPS - 1);

  state_t           state;
  state_t           stateNxt;
  logic [CNT_W-1:0] fillCnt;
  logic             capPend;
  logic             acc;
  logic             armCap;
  logic             capFire;
  logic             startIdle;
  logic             flushDone;

  fir_coef_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .ADDR_W     (ADDR_W)
  ) uCoefBank (
    .clk        (clk),
    .rstN       (rstN),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .coefs      (coefs)
  );

  // start is only honoured from IDLE; it also wipes the tap window.
  assign startIdle = (state == IDLE) && start;

  // FILL always takes samples; RUN takes one unless a result is already
  // waiting behind a stalled output register.
  assign s_ready = (state == FILL) ||
                   ((state == RUN) && (!capPend || !m_valid || m_ready));

  assign acc        = s_valid && s_ready;
  assign shift_en   = acc;
  assign shift_data = s_data;
  assign shift_clr  = startIdle;

  // An accepted sample owes a result once the window is full: every RUN
  // sample, plus the one that completes the fill.
  assign armCap = acc && ((state == RUN) || ((state == FILL) && (fillCnt == LAST_FILL)));

  // The MAC output is sampled while the output register is free or draining.
  // The tap register shifts on the same edge, so the MAC still shows the
  // window of the sample that armed the capture.
  assign capFire = capPend && (!m_valid || m_ready);

  assign flushDone = !capPend && (!m_valid || m_ready);

  assign busy    = (state != IDLE);
  assign state_o = state;

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next-state decode; start beats stop in IDLE, stop beats window completion in FILL.
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (start) stateNxt = FILL;
      end
      FILL: begin
        if (stop)        stateNxt = FLUSH;
        else if (armCap) stateNxt = RUN;
      end
      RUN: begin
        if (stop) stateNxt = FLUSH;
      end
      FLUSH: begin
        if (flushDone) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Fill counter: cleared on start, counts samples accepted while filling.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fillCnt <= '0;
    end else if (startIdle) begin
      fillCnt <= '0;
    end else if ((state == FILL) && acc) begin
      fillCnt <= fillCnt + CNT_W'(1);
    end
  end

  // Pending-capture flag: consumed by a capture, re-armed by an acceptance on the same edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)        capPend <= 1'b0;
    else if (capFire) capPend <= armCap;
    else if (armCap)  capPend <= 1'b1;
  end

  // One-entry output stage: load on capture, clear on a handshake with
  // nothing behind it, otherwise hold data stable.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (capFire) begin
      m_valid <= 1'b1;
      m_data  <= mac_result;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer and configuration front-end for the FIR datapath (tap shift register plus combinational MAC).
- Owns a double-buffered coefficient bank written by the CV32E40X-side config port.
- Gates sample intake with a valid/ready handshake and suppresses outputs until the tap window is full.
- Registers each result into a one-entry output stage with valid/ready backpressure, sustaining one sample per clock.

Parameters:
- DATA_WIDTH, 16, width of samples, coefficients and result.
- NUM_TAPS, 8, number of taps / coefficients.
- ADDR_W, $clog2(NUM_TAPS), coefficient address width.

Ports:
- clk  in  1  clock
- rstN  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin filtering (honoured only in IDLE)
- stop  in  1  pulse; end filtering (honoured only in FILL/RUN)
- cfg_we  in  1  shadow coefficient write strobe
- cfg_addr  in  ADDR_W  shadow coefficient index
- cfg_wdata  in  DATA_WIDTH  coefficient value
- cfg_commit  in  1  pulse; copy shadow bank to active bank
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  raw sample
- shift_en  out  1  advance tap shift register (equals s_valid && s_ready)
- shift_clr  out  1  synchronous clear of all taps
- shift_data  out  DATA_WIDTH  equals s_data
- coefs  out  NUM_TAPS*DATA_WIDTH  active bank; tap i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- mac_result  in  DATA_WIDTH  combinational MAC of current tap window with coefs
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_data  out  DATA_WIDTH  registered result
- busy  out  1  state != IDLE
- state_o  out  2  IDLE=0, FILL=1, RUN=2, FLUSH=3

Behaviour:
- Reset: state IDLE; fill_cnt 0; cap_pend 0; m_valid 0; m_data 0; shadow and active banks all 0; s_ready 0; shift_en 0; shift_clr 0.
- Accept: acc = s_valid && s_ready. shift_en = acc. shift_data = s_data.
- IDLE:
  - s_ready = 0.
  - start → FILL. shift_clr = 1 during the start cycle; fill_cnt ← 0.
  - stop is ignored.
- FILL:
  - s_ready = 1.
  - Each acc increments fill_cnt.
  - The acc that brings fill_cnt to NUM_TAPS moves the block to RUN and sets cap_pend; this is the first result-producing sample.
  - Earlier samples produce no output.
- RUN:
  - s_ready = !cap_pend || !m_valid || m_ready.
  - acc sets cap_pend.
- Capture: on any edge with cap_pend && (!m_valid || m_ready):
  - m_data ← mac_result, m_valid ← 1.
  - cap_pend ← acc (a new acceptance on the same edge re-arms it).
  - Correctness: mac_result reflects the pre-shift window at that edge.
- Output handshake: m_valid && m_ready with no capture on that edge → m_valid ← 0. m_data is held stable while m_valid && !m_ready.
- Latency: sample accepted at edge k (in RUN, or the final FILL sample) → m_valid high after edge k+1 at the earliest. Throughput is 1 sample/clk with m_ready held high.
- stop in FILL or RUN → FLUSH:
  - s_ready = 0.
  - cap_pend continues to capture.
  - Exit to IDLE on the edge where cap_pend == 0 and (m_valid == 0, or m_valid && m_ready).
  - Partial FILL windows are discarded, never output.
- start in FILL/RUN/FLUSH is ignored.
- start and stop asserted together in IDLE: start wins.
- Coefficients:
  - cfg_we writes shadow[cfg_addr] at the next edge, in any state.
  - cfg_commit copies shadow to active at the next edge.
  - A cfg_we in the same cycle as cfg_commit is not included in that commit.
  - A result uses the active bank at its capture edge; commit mid-RUN is legal.
- cfg_addr >= NUM_TAPS: write is dropped.
- Async reset mid-operation: all state returns to reset values immediately; an in-flight result is lost.

Decomposition:
- Package fir_pkg holds:
  - DATA_WIDTH and NUM_TAPS defaults, matching existing constants.
  - state_t enum {IDLE, FILL, RUN, FLUSH}.
  - coef_bank_t typedef (array [NUM_TAPS] of DATA_WIDTH).
- One sub-module, fir_coef_bank: shadow/active registers with write, commit and address-range check.
- FSM, capture and handshake logic live in fir_seq_ctrl.
- The tap shift register must gain shift_en/shift_clr inputs; the bench instantiates that register plus the MAC around the DUT.

Test Plan:
All cases use NUM_TAPS=4, DATA_WIDTH=16 and y = Σ c[i]·x[n−i].
- Write coefs 1,2,3,4, commit, start, stream samples 1..6 with m_ready=1 → no output for 1..3; outputs 20, 30, 40, one per clk; each appears 1 edge after its accept.
- Same stream, m_ready=0 for 5 cycles after the first result → m_data holds 20; s_ready drops after one further accept; on release, 30 then 40 follow with no loss or duplication.
- Mid-RUN: write shadow to 1,1,1,1 and commit between samples 5 and 6 → result for sample 6 equals 6+5+4+3 = 18.
- stop after 2 FILL samples → FLUSH then IDLE within 1 cycle with no m_valid. Restart with 4,5,6,7 and coefs 1,2,3,4 → first result 7+12+15+16 = 50, confirming the clear.
- stop while one result is pending and m_ready=0 → busy stays 1 until the result is taken, then IDLE. start during FLUSH is ignored.
- Assert rstN low mid-RUN with m_valid=1 → m_valid, busy and s_ready go to 0 asynchronously; coefs read back as 0.
